// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline. It handles load-use, taken-branch
// and D-cache-miss hazards, and keeps saturating stall/flush event counters for debug.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             dcache_miss_i,
  input  logic             dcache_ready_i,
  output logic             pc_write_o,
  output logic             hazard_IF_ID_o,
  output logic             flush_IF_ID_o,
  output logic             bubble_ID_EX_o,
  output logic             stall_all_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] MISS = 1'b1;

  logic [0:0] state;
  logic       load_use;

  assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  // A frozen pipe takes precedence over everything else: a bubble would be lost,
  // and any branch or load-use is re-evaluated once the pipe moves again.
  always_comb begin
    pc_write_o     = 1'b1;
    hazard_IF_ID_o = 1'b0;
    flush_IF_ID_o  = 1'b0;
    bubble_ID_EX_o = 1'b0;
    stall_all_o    = 1'b0;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      hazard_IF_ID_o = 1'b1;
      bubble_ID_EX_o = 1'b1;
    end else if (state == MISS || dcache_miss_i) begin
      pc_write_o     = 1'b0;
      hazard_IF_ID_o = 1'b1;
      stall_all_o    = 1'b1;
    end else if (load_use) begin
      pc_write_o     = 1'b0;
      hazard_IF_ID_o = 1'b1;
      bubble_ID_EX_o = 1'b1;
    end else if (branch_taken_i) begin
      flush_IF_ID_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (dcache_miss_i)  state <= MISS;
        MISS:    if (dcache_ready_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_IF_ID_o && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Expected values are queued when each step is
// driven and then popped and compared against the DUT outputs.
module tb_pipeline_hazard_ctrl;

  localparam int W = 4;

  // The control vector is {pc_write, hazard, flush, bubble, stall_all}.
  localparam logic [4:0] C_RST  = 5'b01010;
  localparam logic [4:0] C_LU   = 5'b01010;
  localparam logic [4:0] C_FRZ  = 5'b01001;
  localparam logic [4:0] C_BR   = 5'b10100;
  localparam logic [4:0] C_NORM = 5'b10000;

  typedef struct {
    string        tag;
    logic [4:0]   ctrl;
    logic [W-1:0] sc;
    logic [W-1:0] fc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   id_rs, id_rt, ex_rt;
  logic         ex_memread, branch_taken, dcache_miss, dcache_ready;
  logic         pc_write, hazard, flush, bubble, stall_all;
  logic [W-1:0] stall_cnt, flush_cnt;

  exp_t         q[$];
  logic [W-1:0] m_sc, m_fc;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .ex_memread_i   (ex_memread),
    .ex_rt_i        (ex_rt),
    .branch_taken_i (branch_taken),
    .dcache_miss_i  (dcache_miss),
    .dcache_ready_i (dcache_ready),
    .pc_write_o     (pc_write),
    .hazard_IF_ID_o (hazard),
    .flush_IF_ID_o  (flush),
    .bubble_ID_EX_o (bubble),
    .stall_all_o    (stall_all),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // Drive one cycle and queue its expected control vector together with the counter
  // values expected after the edge; then compare both.
  task automatic step(input string tag, input logic r, input logic [4:0] rs,
                      input logic [4:0] rt, input logic mr, input logic [4:0] ert,
                      input logic br, input logic ms, input logic rd,
                      input logic [4:0] ctrl);
    exp_t e;
    logic [4:0] obs;
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; ex_memread = mr; ex_rt = ert;
    branch_taken = br; dcache_miss = ms; dcache_ready = rd;
    if (r) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (!ctrl[4] && m_sc != '1) m_sc = m_sc + 1'b1;
      if (ctrl[2]  && m_fc != '1) m_fc = m_fc + 1'b1;
    end
    e.tag = tag; e.ctrl = ctrl; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
    #1;
    e = q.pop_front();
    obs = {pc_write, hazard, flush, bubble, stall_all};
    checks++;
    assert (obs === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl: got %b expected %b", e.tag, obs, e.ctrl);
    end
    @(posedge clk);
    #1;
    checks++;
    assert ({stall_cnt, flush_cnt} === {e.sc, e.fc}) else begin
      errors++;
      $error("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
             e.tag, stall_cnt, flush_cnt, e.sc, e.fc);
    end
  endtask

  initial begin
    m_sc = '0; m_fc = '0;
    rst = 1'b1; id_rs = '0; id_rt = '0; ex_memread = 1'b0; ex_rt = '0;
    branch_taken = 1'b0; dcache_miss = 1'b0; dcache_ready = 1'b0;

    step("reset0",    1, 0, 0, 0, 0, 0, 0, 0, C_RST);
    step("reset1",    1, 0, 0, 0, 0, 0, 0, 0, C_RST);
    step("idle",      0, 0, 0, 0, 0, 0, 0, 0, C_NORM);

    step("lu_rs",     0, 5, 0, 1, 5, 0, 0, 0, C_LU);
    step("lu_after",  0, 5, 0, 0, 5, 0, 0, 0, C_NORM);
    step("lu_r0",     0, 0, 0, 1, 0, 0, 0, 0, C_NORM);
    step("lu_rt",     0, 1, 7, 1, 7, 0, 0, 0, C_LU);
    step("lu_nomatch",0, 1, 2, 1, 7, 0, 0, 0, C_NORM);

    step("br",        0, 0, 0, 0, 0, 1, 0, 0, C_BR);
    step("br_after",  0, 0, 0, 0, 0, 0, 0, 0, C_NORM);
    step("br_lu",     0, 3, 0, 1, 3, 1, 0, 0, C_LU);
    step("br_held",   0, 3, 0, 0, 3, 1, 0, 0, C_BR);

    step("miss_t",    0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    step("miss_t1",   0, 0, 0, 0, 0, 0, 0, 0, C_FRZ);
    step("miss_brlu", 0, 4, 0, 1, 4, 1, 0, 0, C_FRZ);
    step("miss_rdy",  0, 0, 0, 0, 0, 1, 0, 1, C_FRZ);
    step("miss_run",  0, 0, 0, 0, 0, 0, 0, 0, C_NORM);

    step("mr_same",   0, 0, 0, 0, 0, 0, 1, 1, C_FRZ);
    step("mr_held",   0, 0, 0, 0, 0, 0, 0, 0, C_FRZ);
    step("mr_rdy",    0, 0, 0, 0, 0, 0, 0, 1, C_FRZ);
    step("mr_run",    0, 0, 0, 0, 0, 0, 0, 0, C_NORM);
    step("rdy_in_run",0, 0, 0, 0, 0, 0, 0, 1, C_NORM);
    step("rdy_run2",  0, 0, 0, 0, 0, 0, 0, 0, C_NORM);

    step("rm_miss",   0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    step("rm_reset",  1, 0, 0, 0, 0, 0, 0, 0, C_RST);
    step("rm_after",  0, 0, 0, 0, 0, 0, 0, 0, C_NORM);

    for (int i = 0; i < 20; i++)
      step("sat",     0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    checks++;
    assert (stall_cnt === 4'd15) else begin
      errors++;
      $error("FAIL sat_value: got %0d expected 15", stall_cnt);
    end
    step("sat_rdy",   0, 0, 0, 0, 0, 0, 0, 1, C_FRZ);
    step("sat_run",   0, 0, 0, 0, 0, 0, 0, 0, C_NORM);
    checks++;
    assert (stall_cnt === 4'd15) else begin
      errors++;
      $error("FAIL sat_hold: got %0d expected 15", stall_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It owns the IF/ID register's `hazard_IF_ID_i` (stall) and `flush_i` inputs, the PC write enable, the ID/EX bubble insert and a global freeze for data-cache misses. It sequences three hazard sources: load-use, taken branch/jump resolved in ID, and multi-cycle D-cache miss. Saturating event counters are provided for debug.

## Interface
Parameters:
- `CNT_W`, 16, width of the stall and flush event counters.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `id_rs_i`  in  5  rs field of the instruction in ID.
- `id_rt_i`  in  5  rt field of the instruction in ID.
- `ex_memread_i`  in  1  instruction in EX is a load.
- `ex_rt_i`  in  5  destination register of the load in EX.
- `branch_taken_i`  in  1  branch or jump in ID resolved taken this cycle.
- `dcache_miss_i`  in  1  MEM-stage access missed this cycle.
- `dcache_ready_i`  in  1  miss fill complete; data valid this cycle.
- `pc_write_o`  out  1  PC load enable.
- `hazard_IF_ID_o`  out  1  stall (hold) IF/ID; drives `hazard_IF_ID_i` of the IF/ID register.
- `flush_IF_ID_o`  out  1  replace the IF/ID instruction with 0 (nop).
- `bubble_ID_EX_o`  out  1  zero the ID/EX control fields.
- `stall_all_o`  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- `stall_cnt_o`  out  CNT_W  cycles with `pc_write_o`=0.
- `flush_cnt_o`  out  CNT_W  cycles with `flush_IF_ID_o`=1.

## Operation
- FSM has two states, RUN and MISS. Reset state is RUN.
- The control outputs are combinational from the state and the inputs. The counters are registered.
- Load-use condition `lu`: `ex_memread_i` && `ex_rt_i`!=0 && (`ex_rt_i`==`id_rs_i` || `ex_rt_i`==`id_rt_i`).
- Output priority (highest first):
  - `rst_i`=1: `pc_write`=0, `hazard`=1, `bubble`=1, `flush`=0, `stall_all`=0.
  - state MISS, or RUN with `dcache_miss_i`=1: `stall_all`=1, `hazard`=1, `pc_write`=0, `bubble`=0, `flush`=0. The whole pipe is frozen, so no bubble is inserted.
  - RUN with `lu`=1: `hazard`=1, `pc_write`=0, `bubble`=1, `flush`=0. `branch_taken_i` is ignored because its operands are stale; the branch re-resolves next cycle.
  - RUN with `branch_taken_i`=1: `flush`=1, `pc_write`=1 (PC takes the target), `hazard`=0, `bubble`=0.
  - Otherwise: `pc_write`=1 and all other control outputs are 0.
- Transitions:
  - RUN→MISS on an edge where `dcache_miss_i`=1.
  - MISS→RUN on an edge where `dcache_ready_i`=1.
  - `dcache_ready_i` is ignored in RUN. `dcache_miss_i` is ignored in MISS.
- Counters:
  - Each counter increments by 1 on each edge where its qualifying output was 1 in that cycle and `rst_i`=0.
  - Both saturate at all-ones and never wrap.
  - Reset clears both to 0.

## Timing
- Load-use costs exactly one stall cycle. `lu` clears on the next cycle because the load has moved on to MEM.
- A taken branch costs one flushed fetch. `flush` is asserted in the same cycle as `branch_taken_i`.
- A miss detected in cycle t stalls cycles t through r inclusive, where r is the first cycle in MISS with `dcache_ready_i`=1. Cycle r+1 is RUN. For `ready` arriving k cycles after the miss cycle, the stall length is k+1 cycles.
- Simultaneous events:
  - miss + load-use + branch: miss wins. After the miss, the load-use and branch are re-evaluated from the held pipeline state.
  - miss and ready in the same RUN cycle: enter MISS; that `ready` is ignored.
- Reset mid-miss: on the reset edge the state goes to RUN, the counters go to 0, and the pending fill is abandoned.
- Output values during `rst_i`=1 are as listed in Operation. After `rst_i` falls, the first cycle is RUN.

## Test plan
- Load-use: `ex_memread`=1, `ex_rt`=5, `id_rs`=5 for one cycle, then `ex_memread`=0 → cycle 1: `pc_write`=0, `hazard`=1, `bubble`=1; cycle 2: `pc_write`=1, all others 0; `stall_cnt`=1. Repeat with `ex_rt`=0 → no stall.
- Branch: `branch_taken`=1 for one cycle → `flush`=1, `pc_write`=1, `hazard`=0; `flush_cnt`=1. With `lu` asserted in the same cycle → `flush`=0, stall only; branch held the next cycle → `flush`=1.
- Miss: `dcache_miss` pulse at t, `dcache_ready` at t+3 → `stall_all`=1 and `pc_write`=0 for t..t+3 (4 cycles); RUN at t+4; `stall_cnt`=4. A concurrent `branch_taken`/`lu` produces no `flush`/`bubble` during this window.
- Saturation: with `CNT_W`=4, hold a miss for 20 cycles → `stall_cnt`=15 and stays 15.
- Reset mid-miss: `rst_i`=1 at t+1 of a miss → during reset `hazard`=1, `bubble`=1, `stall_all`=0; after release, RUN with counters 0 and `pc_write`=1.
